// File: rtl/keccak_pkg_mine.sv
// Shared types and constants for the Keccak core request arbiter.
package keccak_pkg_mine;

    localparam int unsigned w = 64;

    // Output-length field position inside the header word.
    localparam int unsigned OLEN_LSB = 0;
    localparam int unsigned OLEN_W   = 32;
    localparam int unsigned CNT_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INPUT  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

endpackage

// File: rtl/keccak_arbiter.sv
// Two-requester round-robin front end for a single Keccak core: one request's
// message in, then exactly ceil(OLEN/W) result words back to the same requester.
module keccak_arbiter
    import keccak_pkg_mine::*;
#(
    parameter int unsigned W = w
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    input  logic         req0_last,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    output logic         resp0_valid,
    output logic [W-1:0] resp0_data,
    input  logic         resp0_ready,

    input  logic         req1_valid,
    input  logic         req1_last,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         resp1_valid,
    output logic [W-1:0] resp1_data,
    input  logic         resp1_ready,

    output logic         k_valid_n,
    output logic         k_ready_n,
    output logic [W-1:0] k_data,
    input  logic         k_ready,
    input  logic         k_valid,
    input  logic [W-1:0] k_dout
);

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic               first_q, first_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               sel_valid;
    logic               sel_last;
    logic [W-1:0]       sel_data;
    logic               sel_resp_ready;
    logic [OLEN_W-1:0]  olen;
    logic [OLEN_W:0]    olen_sum;
    logic [CNT_W-1:0]   owords;
    logic               pick;
    logic               in_xfer;
    logic               out_xfer;

    // Granted-requester view of the input and response channels.
    assign sel_valid      = grant_q ? req1_valid  : req0_valid;
    assign sel_last       = grant_q ? req1_last   : req0_last;
    assign sel_data       = grant_q ? req1_data   : req0_data;
    assign sel_resp_ready = grant_q ? resp1_ready : resp0_ready;

    // Word count from the header; a zero length still yields one word.
    assign olen     = sel_data[OLEN_LSB +: OLEN_W];
    assign olen_sum = {1'b0, olen} + (OLEN_W+1)'(W - 1);
    assign owords   = (olen == '0) ? CNT_W'(1) : CNT_W'(olen_sum / (OLEN_W+1)'(W));

    assign in_xfer  = (state_q == ST_INPUT)  && sel_valid && k_ready;
    assign out_xfer = (state_q == ST_OUTPUT) && k_valid   && sel_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            first_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_q      <= first_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_d      = first_q;
        cnt_d        = cnt_q;
        pick         = 1'b0;

        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        resp0_data   = '0;
        resp1_data   = '0;
        k_data       = '0;
        k_valid_n    = 1'b1;
        k_ready_n    = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the requester not served last time wins.
                    pick         = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    grant_d      = pick;
                    last_grant_d = pick;
                    first_d      = 1'b1;
                    state_d      = ST_INPUT;
                end
            end
            ST_INPUT: begin
                if (in_xfer) begin
                    first_d = 1'b0;
                    if (first_q) begin
                        cnt_d = owords;
                    end
                    if (sel_last) begin
                        state_d = ST_OUTPUT;
                    end
                end
            end
            ST_OUTPUT: begin
                if (out_xfer) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pass-through paths, forced to their idle values while in reset.
        if (!rst) begin
            if (state_q == ST_INPUT) begin
                k_data    = sel_data;
                k_valid_n = ~sel_valid;
                if (grant_q) req1_ready = k_ready;
                else         req0_ready = k_ready;
            end
            if (state_q == ST_OUTPUT) begin
                k_ready_n = ~sel_resp_ready;
                if (grant_q) begin
                    resp1_valid = k_valid;
                    resp1_data  = k_dout;
                end else begin
                    resp0_valid = k_valid;
                    resp0_data  = k_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter; the bench plays both requesters and the core.
module tb_keccak_arbiter;

    localparam int unsigned TW = 64;

    logic          clk;
    logic          rst;
    logic          req0_valid, req0_last, req0_ready;
    logic [TW-1:0] req0_data;
    logic          resp0_valid, resp0_ready;
    logic [TW-1:0] resp0_data;
    logic          req1_valid, req1_last, req1_ready;
    logic [TW-1:0] req1_data;
    logic          resp1_valid, resp1_ready;
    logic [TW-1:0] resp1_data;
    logic          k_valid_n, k_ready_n, k_ready, k_valid;
    logic [TW-1:0] k_data, k_dout;

    int total = 0;
    int bad   = 0;
    int wt;

    keccak_arbiter #(.W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_last   (req0_last),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .resp0_valid (resp0_valid),
        .resp0_data  (resp0_data),
        .resp0_ready (resp0_ready),
        .req1_valid  (req1_valid),
        .req1_last   (req1_last),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .resp1_valid (resp1_valid),
        .resp1_data  (resp1_data),
        .resp1_ready (resp1_ready),
        .k_valid_n   (k_valid_n),
        .k_ready_n   (k_ready_n),
        .k_data      (k_data),
        .k_ready     (k_ready),
        .k_valid     (k_valid),
        .k_dout      (k_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] hdr_of(input int g, input logic [31:0] olen);
        return {32'hC0DE_0000 | 32'(g), olen};
    endfunction

    function automatic logic rdy(input int g);
        return (g == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic other_rdy(input int g);
        return (g == 1) ? req0_ready : req1_ready;
    endfunction

    function automatic logic respv(input int g);
        return (g == 1) ? resp1_valid : resp0_valid;
    endfunction

    function automatic logic other_respv(input int g);
        return (g == 1) ? resp0_valid : resp1_valid;
    endfunction

    function automatic logic [TW-1:0] respd(input int g);
        return (g == 1) ? resp1_data : resp0_data;
    endfunction

    task automatic set_req(input int g, input logic v, input logic [TW-1:0] d, input logic l);
        if (g == 1) begin
            req1_valid = v; req1_data = d; req1_last = l;
        end else begin
            req0_valid = v; req0_data = d; req0_last = l;
        end
    endtask

    task automatic set_resp_ready(input int g, input logic r);
        if (g == 1) resp1_ready = r;
        else        resp0_ready = r;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rdy0"},  TW'(req0_ready),  TW'(0));
        chk({tag, "_rdy1"},  TW'(req1_ready),  TW'(0));
        chk({tag, "_rv0"},   TW'(resp0_valid), TW'(0));
        chk({tag, "_rv1"},   TW'(resp1_valid), TW'(0));
        chk({tag, "_kvn"},   TW'(k_valid_n),   TW'(1));
        chk({tag, "_krn"},   TW'(k_ready_n),   TW'(1));
    endtask

    // Entered just after a falling edge: request g, feed nin words, drain the result.
    task automatic serve(input int g, input logic [31:0] olen, input int nin, input int exp_out,
                         input bit toggle, input bit hold, output int waitc);
        logic [TW-1:0] hdr, wd, exp_d;
        int  got;
        bit  done;
        logic rr;
        hdr   = hdr_of(g, olen);
        waitc = 0;
        for (int c = 0; c < 16; c++) begin
            set_req(g, 1'b1, hdr, 1'(nin == 1));
            #1;
            if (rdy(g)) break;
            waitc++;
            @(negedge clk);
        end
        chk("grant_ready", TW'(rdy(g)), TW'(1));
        chk("hdr_kdata", k_data, hdr);
        chk("hdr_kvalid_n", TW'(k_valid_n), TW'(0));
        chk("hdr_other_ready", TW'(other_rdy(g)), TW'(0));
        for (int i = 1; i < nin; i++) begin
            @(negedge clk);
            wd = 64'h1111_0000_0000_0000 + TW'(i) + (TW'(g) << 8);
            set_req(g, 1'b1, wd, 1'(i == nin - 1));
            #1;
            chk("word_kdata", k_data, wd);
            chk("word_ready", TW'(rdy(g)), TW'(1));
        end
        got  = 0;
        done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (c == 0) set_req(g, 1'(hold), hdr, 1'(nin == 1));
            rr      = toggle ? 1'(c % 2 == 0) : 1'b1;
            k_valid = 1'b1;
            exp_d   = 64'hD0D0_0000_0000_0000 + TW'(got);
            k_dout  = exp_d;
            set_resp_ready(g, rr);
            #1;
            if (!respv(g)) begin
                done = 1;
                chk("end_kready_n", TW'(k_ready_n), TW'(1));
            end else begin
                chk("resp_data", respd(g), exp_d);
                chk("kready_n_mirror", TW'(k_ready_n), TW'(!rr));
                chk("other_resp_valid", TW'(other_respv(g)), TW'(0));
                if (rr) got++;
            end
        end
        k_valid = 1'b0;
        set_resp_ready(g, 1'b1);
        chk("out_done", TW'(done), TW'(1));
        chk("out_words", TW'(got), TW'(exp_out));
    endtask

    initial begin
        // Reset with every input active: outputs must still sit at idle values.
        rst = 1'b1;
        req0_valid = 1'b1; req0_last = 1'b1; req0_data = 64'hFFFF_FFFF_FFFF_FFFF;
        req1_valid = 1'b1; req1_last = 1'b1; req1_data = 64'hFFFF_FFFF_FFFF_FFFF;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        k_ready = 1'b1; k_valid = 1'b1; k_dout = 64'hDEAD_BEEF_0000_0001;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        chk("reset_kdata", k_data, TW'(0));
        chk("reset_rd0", resp0_data, TW'(0));
        chk("reset_rd1", resp1_data, TW'(0));
        req0_valid = 1'b0; req1_valid = 1'b0; k_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Simultaneous first request: req0 wins, req1 follows right after.
        set_req(1, 1'b1, hdr_of(1, 32'd128), 1'b1);
        serve(0, 32'd256, 3, 4, 1'b0, 1'b0, wt);
        chk("first_tie_wait0", TW'(wt), TW'(1));
        serve(1, 32'd128, 1, 2, 1'b0, 1'b0, wt);
        chk("first_tie_wait1", TW'(wt), TW'(1));

        // Backpressure on resp0 and a 1344-bit result.
        serve(0, 32'd1344, 2, 21, 1'b1, 1'b0, wt);

        // Zero length, header only.
        serve(1, 32'd0, 1, 1, 1'b0, 1'b0, wt);

        // Fairness with both requesters held valid.
        set_req(1, 1'b1, hdr_of(1, 32'd64), 1'b1);
        serve(0, 32'd64, 1, 1, 1'b0, 1'b1, wt);
        chk("fair_wait_a", TW'(wt), TW'(1));
        serve(1, 32'd64, 1, 1, 1'b0, 1'b1, wt);
        chk("fair_wait_b", TW'(wt), TW'(1));
        serve(0, 32'd64, 1, 1, 1'b0, 1'b0, wt);
        chk("fair_wait_c", TW'(wt), TW'(1));
        serve(1, 32'd64, 1, 1, 1'b0, 1'b0, wt);
        chk("fair_wait_d", TW'(wt), TW'(1));

        // Reset while the result is streaming out.
        set_req(0, 1'b1, hdr_of(0, 32'd512), 1'b1);
        @(negedge clk);
        #1;
        chk("mr_in_ready", TW'(req0_ready), TW'(1));
        @(negedge clk);
        req0_valid = 1'b0;
        k_valid = 1'b1; k_dout = 64'h5555_0000_0000_0001;
        #1;
        chk("mr_out_valid", TW'(resp0_valid), TW'(1));
        @(negedge clk);
        #1;
        chk("mr_out_valid2", TW'(resp0_valid), TW'(1));
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs("mr_rst");
        chk("mr_rst_kdata", k_data, TW'(0));
        chk("mr_rst_rd0", resp0_data, TW'(0));
        rst = 1'b0;
        #1;
        check_idle_outputs("mr_after");
        k_valid = 1'b0;
        set_req(1, 1'b1, hdr_of(1, 32'd64), 1'b1);
        serve(0, 32'd64, 1, 1, 1'b0, 1'b0, wt);
        chk("mr_tie_wait0", TW'(wt), TW'(1));
        serve(1, 32'd64, 1, 1, 1'b0, 1'b0, wt);
        chk("mr_tie_wait1", TW'(wt), TW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keccak_arbiter.md
KECCAK_ARBITER -- requirements
Module: keccak_arbiter

Interface
REQ-001 Parameter W, default w (keccak_pkg_mine), SHALL set the data word width for every data port.
REQ-002 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an input word.
REQ-005 reqN_last  input  1  marks requester N's final input word.
REQ-006 reqN_data  input  W  requester N's input word; the first word of each request is the header.
REQ-007 reqN_ready  output  1  the arbiter accepts requester N's word this cycle.
REQ-008 respN_valid  output  1  an output word is presented to requester N.
REQ-009 respN_data  output  W  output word for requester N.
REQ-010 respN_ready  input  1  requester N accepts the output word.
REQ-011 k_valid_n  output  1  drives the core's valid_in, active-low.
REQ-012 k_ready_n  output  1  drives the core's ready_in, active-low.
REQ-013 k_data  output  W  drives the core's data_in.
REQ-014 k_ready  input  1  the core's ready_out, active-high.
REQ-015 k_valid  input  1  the core's valid_out, active-high.
REQ-016 k_dout  input  W  the core's data_out.

Function
REQ-017 Header word: bits[31:0] are the output length in bits (OLEN); the bits above 31 pass to the core unchanged.
REQ-018 The arbiter SHALL compute the output word count OWORDS = ceil(OLEN/W), with OLEN=0 treated as W.
REQ-019 The state machine SHALL have the states IDLE, INPUT and OUTPUT, with exactly one transaction in flight at a time.
REQ-020 IDLE: if any reqN_valid is asserted, grant one requester in the same cycle; if both are asserted, grant the requester that is not last_grant (round-robin).
REQ-021 IDLE, no reqN_valid asserted: remain in IDLE.
REQ-022 A grant SHALL update last_grant and move the state to INPUT in the next cycle.
REQ-023 INPUT, data path: k_data=reqG_data and k_valid_n=!reqG_valid.
REQ-024 INPUT, handshake: reqG_ready=k_ready; a word transfers when reqG_valid and k_ready are both 1.
REQ-025 The first word transferred in INPUT SHALL load OLEN into a 32-bit-capable down-counter of OWORDS.
REQ-026 A transferred word with reqG_last=1 SHALL move the state to OUTPUT.
REQ-027 The non-granted requester SHALL see reqN_ready=0 and respN_valid=0 throughout the transaction.
REQ-028 OUTPUT, data path: respG_data=k_dout, respG_valid=k_valid and k_ready_n=!respG_ready.
REQ-029 OUTPUT, counting: each word with k_valid and respG_ready both 1 SHALL decrement the counter.
REQ-030 A transfer that brings the counter to zero SHALL return the state to IDLE in the next cycle.
REQ-031 A header with reqG_last=1 (empty message) SHALL be legal and go straight to OUTPUT.
REQ-032 Outside INPUT: k_valid_n=1.
REQ-033 Outside OUTPUT: k_ready_n=1.
REQ-034 The arbiter SHALL add no data latency: all pass-through paths are combinational from registered grant/state only.

Reset
REQ-035 While rst=1, these outputs SHALL be 0: reqN_ready, respN_valid, respN_data, k_data.
REQ-036 While rst=1, k_valid_n=1 and k_ready_n=1.
REQ-037 Reset SHALL set state=IDLE, counter=0 and last_grant=1, so requester 0 wins the first tie.
REQ-038 Reset mid-transaction SHALL abandon the transaction; the core SHALL be reset by the same rst.

Structure
REQ-039 The state enum and the OLEN field position SHALL live in keccak_pkg_mine.
REQ-040 W SHALL take its value from w in keccak_pkg_mine.
REQ-041 No sub-module: a single flat FSM plus counter.

Verification
REQ-042 Single request: req0 sends a 3-word message with OLEN=256 (W=64) -> exactly 4 words on resp0, then IDLE; resp1_valid stays 0 throughout.
REQ-043 Simultaneous first request: req0 and req1 assert valid in the same cycle after reset -> req0 is served first; req1 is granted the cycle after req0 completes.
REQ-044 Fairness: req0 and req1 both held valid across 4 transactions -> grant order is 0,1,0,1.
REQ-045 Backpressure: resp0_ready toggled every cycle with OLEN=1344 -> 21 words delivered with no loss or duplication; k_ready_n mirrors !resp0_ready.
REQ-046 Zero length: OLEN=0 with header-only last=1 -> exactly 1 output word.
REQ-047 Mid-transaction reset: rst pulsed while in OUTPUT -> all outputs hold their reset values next cycle; a following request completes normally.
